// File: rtl/reg_fifo.sv
// reg_fifo: synchronous FWFT FIFO, d/enable write port, valid/ready read port; REG_FIFO_OVF_EN adds a sticky overflow flag
module reg_fifo #(
  parameter int n     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [n-1:0]  d,
  input  logic          enable,
  output logic          full,
  output logic [n-1:0]  z,
  output logic          valid,
  input  logic          ready,
  output logic [AW:0]   count
`ifdef REG_FIFO_OVF_EN
  , output logic        overflow
`endif
);
  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, push;
  assign valid = count != '0;
  assign full  = count == (AW+1)'(DEPTH);
  assign pop   = valid && ready;
  assign push  = enable && (!full || pop);
  assign z     = valid ? mem[rptr] : '0;
  always_ff @(posedge clk)
    if (resetn && push) mem[wptr] <= d;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
`ifdef REG_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (!resetn) overflow <= 1'b0;
    else if (enable && full && !pop) overflow <= 1'b1;
  end
`endif
endmodule
